imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time writer for the instruction memory: accepts a byte stream over a valid/ready handshake, packs each four bytes big-endian into a 32-bit MIPS instruction, and drives the instruction memory write port at word-aligned byte addresses starting from BASE_ADDR. It sits between the host/UART byte source and the write port of the instruction memory. It holds the CPU (`cpu_hold`) until the programmed image is complete, so fetch never sees a partially written image.

## Interface
- `DEPTH`, 256: instruction memory size in 32-bit words; bounds the legal `num_words`.
- `BASE_ADDR`, 32'h0000_0000: byte address of the first written word; must be word aligned.
- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a load; sampled only in IDLE.
- `num_words`  in  $clog2(DEPTH)+1  number of words to load; sampled with `start`.
- `in_valid`  in  1  byte source has data.
- `in_data`  in  8  byte from source.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `we`  out  1  instruction memory write enable, one-cycle pulse per word.
- `waddr`  out  32  byte write address, always word aligned (`waddr[1:0]`=0).
- `wd`  out  32  write data (assembled instruction).
- `busy`  out  1  load in progress.
- `cpu_hold`  out  1  holds CPU in reset while loading.
- `done`  out  1  one-cycle pulse at end of a load (success or error).
- `err`  out  1  sticky: last `start` had an illegal `num_words`; cleared by the next accepted `start`.

## Operation
- States: IDLE, RECV, WRITE, FIN.
- IDLE: `in_ready`=0. On `start`=1:
  - `num_words`=0 or >DEPTH: `err`<=1, go to FIN, no writes.
  - Otherwise: latch `num_words`, word index<=0, byte count<=0, `err`<=0, go to RECV.
- RECV: `in_ready`=1. A byte is accepted when `in_valid && in_ready`.
  - Byte k (0..3) lands in `wd[31-8k -: 8]`: first byte is the MSB (big-endian).
  - On the 4th accepted byte, go to WRITE.
  - `in_valid`=0 stalls indefinitely with no timeout; the partial word is retained.
- WRITE: `in_ready`=0, `we`=1 for exactly one cycle.
  - `waddr` = BASE_ADDR + 4*index; wraps modulo 2^32.
  - Index increments. If the new index equals the latched count, go to FIN; else clear byte count and go to RECV.
- FIN: `done`=1 for one cycle, then IDLE.
- `start` is ignored outside IDLE. `num_words` changes after sampling have no effect.
- `busy`=1 and `cpu_hold`=1 in RECV, WRITE and FIN; both 0 in IDLE.
- Error path: `busy`=1 only during FIN.
- `wd` and `waddr` are registered and hold their last values outside WRITE; they are meaningful only while `we`=1.

## Timing
- Reset (async assert, sync release): state=IDLE; `we`=0, `waddr`=0, `wd`=0, `in_ready`=0, `busy`=0, `cpu_hold`=0, `done`=0, `err`=0.
- Reset mid-load aborts immediately: the partial word is discarded and words already written stay in memory.
- `start` at edge N: state is RECV at N+1 and `in_ready`=1 in cycle N+1.
- 4th byte accepted at edge M: `we`=1 in cycle M+1. `in_ready` returns to 1 in cycle M+2 if more words remain.
- Minimum 5 cycles per word: 4 RECV + 1 WRITE.
- Last `we` in cycle W: `done`=1 in cycle W+1; IDLE with `busy`=`cpu_hold`=0 at W+2.
- Illegal `start` at edge N: `done`=1 and `err`=1 in cycle N+1; IDLE at N+2.
- Combinational paths: `in_ready` is a function of state only, with no path from `in_valid`.

## Test plan
- Reset defaults: assert `reset` mid-cycle -> all outputs 0 immediately; deassert, hold 3 cycles -> IDLE, `in_ready`=0.
- Single word: `start`, `num_words`=1, bytes 20,08,00,05 back-to-back -> exactly one `we` pulse with `waddr`=0, `wd`=32'h2008_0005; `done` next cycle; `cpu_hold` high from start+1 to done.
- Multi-word with stalls: `num_words`=3, random `in_valid` gaps, words 8C01_0004 / AC02_0008 / 1000_FFFF -> `waddr`=0,4,8 in order with matching `wd`; no extra `we`; `in_ready`=0 in WRITE cycles.
- Illegal count: `num_words`=0, then `num_words`=DEPTH+1 -> no `we`, `done` 1 cycle after each `start`, `err`=1; a following legal start clears `err`.
- Busy ignore: pulse `start` with `num_words`=5 during RECV of a 2-word load -> load ends after 2 words; no restart.
- Abort: assert `reset` after 2 bytes of word 1 (word 0 written) -> IDLE at once, no `we`; a fresh load of 1 word writes `waddr`=0 with new data.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: packs a big-endian byte stream into
// 32-bit words and writes them at consecutive word addresses while the CPU is held.
module imem_loader #(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [$clog2(DEPTH):0] num_words,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  output logic                   we,
  output logic [31:0]            waddr,
  output logic [31:0]            wd,
  output logic                   busy,
  output logic                   cpu_hold,
  output logic                   done,
  output logic                   err,
  output logic [1:0]             dbg_state
);

  localparam int AW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, WRITE = 2'd2, FIN = 2'd3} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] cnt_q;
  logic [AW-1:0] idx_q;
  logic [1:0]    bcnt_q;
  logic [23:0]   word_q;
  logic          accept;
  logic          bad_count;
  logic          last_word;

  // Handshake: a byte transfers on a rising edge where in_valid && in_ready.
  // in_ready depends on state only, so the source may wait on it freely.
  assign accept    = in_valid && in_ready;
  assign bad_count = (num_words == '0) || (num_words > AW'(DEPTH));
  assign last_word = ((idx_q + AW'(1)) == cnt_q);
  assign cpu_hold  = busy;
  assign dbg_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    we        = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = bad_count ? FIN : RECV;
      end
      RECV: begin
        in_ready = 1'b1;
        if (in_valid && bcnt_q == 2'd3) state_nxt = WRITE;
      end
      WRITE: begin
        we        = 1'b1;
        state_nxt = last_word ? FIN : RECV;
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      bcnt_q <= '0;
      word_q <= '0;
      wd     <= '0;
      waddr  <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            err <= bad_count;
            if (!bad_count) begin
              cnt_q  <= num_words;
              idx_q  <= '0;
              bcnt_q <= '0;
            end
          end
        end
        RECV: begin
          if (accept) begin
            // byte counter wraps to 0 on the 4th byte, ready for the next word
            bcnt_q <= bcnt_q + 2'd1;
            if (bcnt_q == 2'd3) begin
              wd    <= {word_q, in_data};
              waddr <= BASE_ADDR + {{(30-AW){1'b0}}, idx_q, 2'b00};
            end else begin
              word_q <= {word_q[15:0], in_data};
            end
          end
        end
        WRITE: idx_q <= idx_q + AW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: reset, single/multi-word loads, illegal counts,
// start-while-busy and mid-load reset abort.
module tb_imem_loader;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  num_words = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready, we, busy, cpu_hold, done, err;
  logic [31:0] waddr, wd;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  logic [31:0] exp_q[$];

  imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .start(start), .num_words(num_words),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .we(we), .waddr(waddr), .wd(wd), .busy(busy), .cpu_hold(cpu_hold),
    .done(done), .err(err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) if (we === 1'b1) we_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 0);
    check({tag, "_we"},       32'(we), 0);
    check({tag, "_waddr"},    waddr, 0);
    check({tag, "_wd"},       wd, 0);
    check({tag, "_busy"},     32'(busy), 0);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 0);
    check({tag, "_done"},     32'(done), 0);
    check({tag, "_err"},      32'(err), 0);
    check({tag, "_state"},    32'(dbg_state), 0);
  endtask

  // driver tasks
  task automatic do_start(input logic [8:0] n);
    start = 1'b1;
    num_words = n;
    step();
    start = 1'b0;
  endtask

  task automatic put_byte(input logic [7:0] b);
    int t = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && t < 50) begin
      step();
      t++;
    end
    check("in_ready_wait", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic put_word(input logic [31:0] w, input int max_gap);
    for (int k = 0; k < 4; k++) begin
      int gap = $urandom_range(0, max_gap);
      for (int g = 0; g < gap; g++) step();
      put_byte(w[31-8*k -: 8]);
    end
  endtask

  // scoreboard: called in the WRITE cycle right after the 4th byte
  task automatic check_write(input string tag, input logic [31:0] exp_addr);
    logic [31:0] exp_w;
    exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check({tag, "_we"},       32'(we), 1);
    check({tag, "_waddr"},    waddr, exp_addr);
    check({tag, "_wd"},       wd, exp_w);
    check({tag, "_in_ready"}, 32'(in_ready), 0);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 1);
  endtask

  task automatic check_done_then_idle(input string tag);
    step();
    check({tag, "_done"},     32'(done), 1);
    check({tag, "_we_off"},   32'(we), 0);
    check({tag, "_hold_fin"}, 32'(cpu_hold), 1);
    step();
    check({tag, "_done_off"}, 32'(done), 0);
    check({tag, "_busy_off"}, 32'(busy), 0);
    check({tag, "_hold_off"}, 32'(cpu_hold), 0);
    check({tag, "_idle"},     32'(dbg_state), 0);
  endtask

  initial begin
    int base;
    logic [31:0] mw[3];
    mw[0] = 32'h8C01_0004;
    mw[1] = 32'hAC02_0008;
    mw[2] = 32'h1000_FFFF;

    // reset defaults: assert mid-cycle, outputs clear without a clock edge
    step();
    step();
    #2 reset = 1'b1;
    #1 check_idle_zero("reset_async");
    step();
    @(negedge clk) reset = 1'b0;
    step(); step(); step();
    check_idle_zero("reset_release");
    we_cnt = 0;

    // single word
    do_start(9'd1);
    check("single_ready", 32'(in_ready), 1);
    check("single_busy", 32'(busy), 1);
    check("single_hold", 32'(cpu_hold), 1);
    check("single_state", 32'(dbg_state), 1);
    exp_q.push_back(32'h2008_0005);
    put_byte(8'h20); put_byte(8'h08); put_byte(8'h00);
    check("single_no_early_we", 32'(we), 0);
    put_byte(8'h05);
    check_write("single", 32'h0);
    check_done_then_idle("single");
    check("single_we_count", 32'(we_cnt), 1);

    // multi-word with random valid gaps
    base = we_cnt;
    do_start(9'd3);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mw[i]);
      put_word(mw[i], 3);
      check_write($sformatf("multi%0d", i), 32'(4 * i));
    end
    check_done_then_idle("multi");
    check("multi_we_count", 32'(we_cnt - base), 3);

    // illegal counts
    base = we_cnt;
    do_start(9'd0);
    check("ill0_done", 32'(done), 1);
    check("ill0_err", 32'(err), 1);
    check("ill0_busy", 32'(busy), 1);
    check("ill0_ready", 32'(in_ready), 0);
    step();
    check("ill0_idle", 32'(dbg_state), 0);
    check("ill0_done_off", 32'(done), 0);
    check("ill0_err_sticky", 32'(err), 1);
    do_start(9'(DEPTH + 1));
    check("ill257_done", 32'(done), 1);
    check("ill257_err", 32'(err), 1);
    step();
    check("ill257_busy_off", 32'(busy), 0);
    check("ill_no_we", 32'(we_cnt - base), 0);
    do_start(9'(DEPTH));
    check("legal_clears_err", 32'(err), 0);
    check("legal_max_recv", 32'(dbg_state), 1);
    reset = 1'b1;
    #1 reset = 1'b0;
    step();
    do_start(9'd1);
    exp_q.push_back(32'h2402_0001);
    put_word(32'h2402_0001, 0);
    check_write("legal_after_err", 32'h0);
    check_done_then_idle("legal_after_err");

    // start ignored while busy
    base = we_cnt;
    do_start(9'd2);
    exp_q.push_back(32'h3C01_1234);
    exp_q.push_back(32'h3421_5678);
    put_byte(8'h3C); put_byte(8'h01);
    do_start(9'd5);
    check("ign_still_recv", 32'(dbg_state), 1);
    put_byte(8'h12); put_byte(8'h34);
    check_write("ign0", 32'h0);
    put_word(32'h3421_5678, 1);
    check_write("ign1", 32'h4);
    check_done_then_idle("ign");
    check("ign_we_count", 32'(we_cnt - base), 2);

    // reset mid-load aborts
    base = we_cnt;
    do_start(9'd3);
    exp_q.push_back(32'h1122_3344);
    put_word(32'h1122_3344, 0);
    check_write("abort_w0", 32'h0);
    put_byte(8'h55); put_byte(8'h66);
    #2 reset = 1'b1;
    #1 check_idle_zero("abort_async");
    step(); step();
    @(negedge clk) reset = 1'b0;
    step();
    check("abort_we_count", 32'(we_cnt - base), 1);
    do_start(9'd1);
    exp_q.push_back(32'h0102_0304);
    put_word(32'h0102_0304, 2);
    check_write("fresh", 32'h0);
    check_done_then_idle("fresh");
    check("exp_q_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
